// File: rtl/object_manager.sv
// ---------------------------------------------------------------------------
// object_manager: per-frame sweep of NUM_OBJ scrolling collectables (spawn/scroll/collide/despawn).
// Optional OBJMGR_SPEEDUP_EN: speed +1 on every 16th collect, capped at SPEED_MAX.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module object_manager #(
  parameter int NUM_OBJ      = 8,
  parameter int SCREEN_WIDTH = 1024,
  parameter int CHAR_WIDTH   = 20,
  parameter int CHAR_HEIGHT  = 20,
  parameter int OBJ_HEIGHT   = 20,
  parameter int Y_MIN        = 32,
  parameter int SPAWN_THRESH = 6,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = 15,
  parameter int SCORE_W      = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [31:0]            random,
  input  logic [9:0]             p_vpos,
  output logic [26*NUM_OBJ-1:0]  obj_bus,
  output logic [SCORE_W-1:0]     score,
  output logic [3:0]             speed,
  output logic                   busy,
  output logic                   overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic               spawned;
  logic [2:0]         anim_cnt;
  logic [25:0]        slot [NUM_OBJ];

  logic [25:0]        cur, slot_nx;
  logic [10:0]        cur_x, cur_y, vpos;
  logic [9:0]         spawn_y;
  logic               occupied, hit, miss, do_spawn, last, collect;
  logic [SCORE_W-1:0] score_inc;
  logic               rand_unused;

  assign rand_unused = &{1'b0, random[27:9]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_START;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_START: if (start)      state_nx = ST_PLAY;
      ST_PLAY:  if (frame_tick) state_nx = ST_SCAN;
      ST_SCAN:  if (last)       state_nx = ST_PLAY;
      default:                  state_nx = ST_START;
    endcase
  end

  // All comparisons run on the pre-update slot contents, widened to 11 bits.
  always_comb begin
    cur       = slot[idx];
    cur_x     = cur[20:10];
    cur_y     = {1'b0, cur[9:0]};
    vpos      = {1'b0, p_vpos};
    occupied  = |cur;
    hit       = (cur_x < 11'(CHAR_WIDTH)) &&
                (cur_y < vpos + 11'(CHAR_HEIGHT)) &&
                (cur_y + 11'(OBJ_HEIGHT) > vpos);
    miss      = cur_x <= {7'd0, speed};
    do_spawn  = !occupied && !spawned && (random[31:28] < 4'(SPAWN_THRESH));
    spawn_y   = 10'(Y_MIN) + {1'b0, random[8:0]};
    last      = (idx == IDX_W'(NUM_OBJ - 1));
    collect   = (state == ST_SCAN) && occupied && hit;
    score_inc = score + SCORE_W'(1);

    slot_nx = cur;
    if (do_spawn)
      slot_nx = {3'd0, 2'd0, 11'(SCREEN_WIDTH - 1), spawn_y};
    else if (occupied && (hit || miss))
      slot_nx = '0;
    else if (occupied)
      slot_nx = {cur[25:23] + {2'd0, anim_cnt == 3'd0}, cur[22:21],
                 cur_x - {7'd0, speed}, cur[9:0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) slot[i] <= '0;
      score    <= '0;
      speed    <= 4'd0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      anim_cnt <= 3'd0;
      idx      <= '0;
      spawned  <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (start) begin
            for (int i = 0; i < NUM_OBJ; i++) slot[i] <= '0;
            speed <= 4'(SPEED_INIT);
            score <= '0;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            idx     <= '0;
            spawned <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_SCAN: begin
          slot[idx] <= slot_nx;
          if (do_spawn) spawned <= 1'b1;
          if (collect && !(&score)) begin
            score <= score_inc;
`ifdef OBJMGR_SPEEDUP_EN
            if (score_inc[3:0] == 4'd0 && speed != 4'(SPEED_MAX))
              speed <= speed + 4'd1;
`endif
          end
          if (frame_tick) overrun <= 1'b1;
          if (last) begin
            busy     <= 1'b0;
            anim_cnt <= anim_cnt + 3'd1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_bus
      assign obj_bus[26*i +: 26] = slot[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_object_manager.sv
// ---------------------------------------------------------------------------
// tb_object_manager: directed sweeps against a behavioural slot model with a result scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_object_manager;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         frame_tick = 1'b0;
  logic [31:0]  random = 32'd0;
  logic [9:0]   p_vpos = 10'd900;
  logic [207:0] obj_bus;
  logic [7:0]   score;
  logic [3:0]   speed;
  logic         busy;
  logic         overrun;

  object_manager dut (
    .clock(clock), .reset_n(reset_n), .start(start), .frame_tick(frame_tick),
    .random(random), .p_vpos(p_vpos), .obj_bus(obj_bus), .score(score),
    .speed(speed), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [207:0] bus;
    logic [7:0]   score;
    logic [3:0]   speed;
  } exp_t;
  exp_t sbq[$];

  logic [25:0] m_slot [8];
  logic [7:0]  m_score;
  logic [3:0]  m_speed;
  logic [2:0]  m_anim;

`ifdef OBJMGR_SPEEDUP_EN
  localparam logic [3:0] SPEED_AFTER_16 = 4'd2;
`else
  localparam logic [3:0] SPEED_AFTER_16 = 4'd1;
`endif

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [207:0] m_bus();
    logic [207:0] b;
    for (int i = 0; i < 8; i++) b[26*i +: 26] = m_slot[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_score = 8'd0;
    m_speed = 4'd0;
    m_anim  = 3'd0;
  endtask

  task automatic model_sweep(input logic [31:0] rnd, input logic [9:0] pv);
    bit sp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [10:0] x, y, v;
      x = m_slot[i][20:10];
      y = {1'b0, m_slot[i][9:0]};
      v = {1'b0, pv};
      if (m_slot[i] == 26'd0) begin
        if (!sp && rnd[31:28] < 4'd6) begin
          m_slot[i] = {5'd0, 11'd1023, 10'd32 + {1'b0, rnd[8:0]}};
          sp = 1'b1;
        end
      end else if (x < 11'd20 && y < v + 11'd20 && y + 11'd20 > v) begin
        m_slot[i] = '0;
        if (m_score != 8'hFF) begin
          m_score = m_score + 8'd1;
`ifdef OBJMGR_SPEEDUP_EN
          if (m_score[3:0] == 4'd0 && m_speed < 4'd15) m_speed = m_speed + 4'd1;
`endif
        end
      end else if (x <= {7'd0, m_speed}) begin
        m_slot[i] = '0;
      end else begin
        m_slot[i][20:10] = x - {7'd0, m_speed};
        if (m_anim == 3'd0) m_slot[i][25:23] = m_slot[i][25:23] + 3'd1;
      end
    end
    m_anim = m_anim + 3'd1;
    sbq.push_back('{bus: m_bus(), score: m_score, speed: m_speed});
  endtask

  // Entered and left at a negative edge.
  task automatic sweep(input logic [31:0] rnd, input logic [9:0] pv, input bit inject);
    int   cnt = 0;
    exp_t e;
    random = rnd;
    p_vpos = pv;
    model_sweep(rnd, pv);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      frame_tick = inject && (cnt == 3);
      cnt++;
      @(negedge clock);
    end
    frame_tick = 1'b0;
    check("busy_cycles", 256'(cnt), 256'(8));
    e = sbq.pop_front();
    check("obj_bus", 256'(obj_bus), 256'(e.bus));
    check("score", 256'(score), 256'(e.score));
    check("speed", 256'(speed), 256'(e.speed));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_speed = 4'd1;
    m_score = 8'd0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_obj_bus", 256'(obj_bus), 256'(0));
    check("rst_score", 256'(score), 256'(0));
    check("rst_speed", 256'(speed), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_overrun", 256'(overrun), 256'(0));
    reset_n = 1'b1;
    @(negedge clock);

    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    check("tick_in_start_busy", 256'(busy), 256'(0));

    do_start();
    check("start_speed", 256'(speed), 256'(1));
    check("start_busy", 256'(busy), 256'(0));

    // First sweep spawns into slot 0; a stray tick mid-sweep is dropped.
    sweep({4'h0, 19'd0, 9'd100}, 10'd900, 1'b1);
    check("spawn_slot0", 256'(obj_bus[25:0]), 256'({3'd0, 2'd0, 11'd1023, 10'd132}));
    check("overrun_set", 256'(overrun), 256'(1));
    repeat (3) @(negedge clock);
    check("no_second_sweep", 256'(busy), 256'(0));

    for (int k = 0; k < 8; k++) sweep(32'hF000_0000, 10'd900, 1'b0);
    check("anim_frame_once", 256'(obj_bus[25:23]), 256'(1));
    check("scrolled_x", 256'(obj_bus[20:10]), 256'(1015));

    for (int k = 0; k < 1100 && m_slot[0] != 26'd0; k++)
      sweep(32'hF000_0000, 10'd900, 1'b0);
    check("missed_cleared", 256'(obj_bus), 256'(0));
    check("missed_no_score", 256'(score), 256'(0));
    check("overrun_sticky", 256'(overrun), 256'(1));

    // Reset asserted in the middle of a sweep.
    random = {4'h0, 19'd0, 9'd100};
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    repeat (2) @(negedge clock);
    check("midsweep_busy", 256'(busy), 256'(1));
    check("midsweep_slot0", 256'(obj_bus[25:0]), 256'({5'd0, 11'd1023, 10'd132}));
    #2 reset_n = 1'b0;
    #1;
    check("abort_obj_bus", 256'(obj_bus), 256'(0));
    check("abort_score", 256'(score), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_speed", 256'(speed), 256'(0));
    check("abort_overrun", 256'(overrun), 256'(0));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_start();
    check("restart_speed", 256'(speed), 256'(1));

    // Continuous spawning at y=200 with the player at 195 until 16 collects.
    for (int k = 0; k < 3000 && m_score < 8'd16; k++)
      sweep({4'h0, 19'd0, 9'd168}, 10'd195, 1'b0);
    check("score_16", 256'(score), 256'(16));
    check("speed_after_16", 256'(speed), 256'(SPEED_AFTER_16));
    check("overrun_clear", 256'(overrun), 256'(0));
    check("queue_drained", 256'(sbq.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
